man_demod: RTL
==============

// Module: man_demod
// PURPOSE
//  Manchester decoder for the 106 kb/s subcarrier link; the receive-side counterpart of the Manchester encoder.
//  Takes the subcarrier-modulated stream (toggling at fc/4 during modulated half-ETUs, static otherwise).
//  Measures subcarrier activity per half-ETU, validates SOF, emits decoded bits with strobes, detects EOF.
//  Sits between the analog front-end comparator and the frame deserializer/CRC checker.
// PARAMETERS
//  HALF_ETU  64  clk cycles per half-ETU (clk = fc = 13.56 MHz -> 128 clk per ETU)
//  CW        6   width of half-ETU cycle counter (must hold HALF_ETU-1)
//  THRESH    8   min in_data transitions in a half-ETU to call it "active"
//  NB_W      9   width of out_nbits (bit counter, saturating)
// PORTS
//  clk        in   1     fc clock, all logic on posedge
//  rst        in   1     asynchronous active-high reset
//  in_enable  in   1     block enable; low = clear to IDLE (synchronous)
//  in_data    in   1     raw subcarrier stream, asynchronous to clk
//  out_data   out  1     decoded bit, valid when out_valid=1
//  out_valid  out  1     1-clk strobe per decoded data bit
//  out_sof    out  1     1-clk strobe when SOF validated
//  out_eof    out  1     1-clk strobe when EOF detected
//  out_err    out  1     1-clk strobe on framing error (frame aborted)
//  out_coll   out  1     1-clk strobe on collision (see CONFIGURATION)
//  out_busy   out  1     high from first detected edge until return to IDLE
//  out_nbits  out  NB_W  data bits in current/last frame; saturates at all-ones
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0. rst dominates in_enable.
//  - in_data: 2-flop synchronizer, then edge detect (either polarity). Edge strobe lags pin by 3 clk.
//  - FSM: IDLE -> SOF_CHK -> DATA -> IDLE.
//  - IDLE: first edge strobe sets out_busy next clk, clears out_nbits, starts half counter at 0.
//    Edge counter starts at 1 (triggering edge counts).
//  - Half counter 0..HALF_ETU-1 wraps; at wrap the half closes: active = (edges >= THRESH); edge count clears.
//  - Halves pair as (A=first, B=second). The pair is evaluated the cycle after B closes; strobes assert that clk.
//  - SOF_CHK: (1,0) -> out_sof, go DATA. Any other pair -> out_err, go IDLE.
//  - DATA, pair decode:
//    (1,0) -> out_data=1, out_valid.
//    (0,1) -> out_data=0, out_valid.
//    (0,0) -> out_eof, go IDLE.
//    (1,1) -> collision (see CONFIGURATION).
//  - out_nbits increments on each out_valid; holds at 2^NB_W-1; holds after frame until next SOF start.
//  - out_data holds last value between strobes. Strobes are mutually exclusive.
//  - Timing is frozen from the first edge; no per-bit resync. Drift beyond THRESH margin is out of scope.
//  - in_enable low: next clk FSM IDLE, counters 0, out_busy 0. No eof/err strobe; out_nbits holds.
//  - Edge strobe during IDLE with in_enable low is ignored.
//  - out_busy drops the clk after out_eof/out_err (same clk IDLE is entered).
// CONFIGURATION
//  MAN_DEMOD_COLL_EN defined:
//    (1,1) in DATA -> out_coll strobe plus out_valid with out_data=1; out_nbits increments; stays in DATA.
//  MAN_DEMOD_COLL_EN undefined:
//    (1,1) in DATA -> out_err, go IDLE; out_coll tied 0.
// TESTING
//  1. rst=1 with in_data toggling -> all outputs 0. Release rst, in_enable=0, toggle -> out_busy stays 0.
//  2. SOF + bits 1,0,1,1 + idle ETU -> out_sof x1; out_valid x4 with data 1,0,1,1; out_eof x1; out_nbits=4.
//     Strobes spaced 128 clk.
//  3. SOF with subcarrier only in second half -> out_err 1 clk after 128 clk; no out_sof; IDLE, out_busy=0.
//  4. Bit 2 active in both halves -> COLL_EN: out_coll + out_valid(data=1), frame continues.
//     Not defined: out_err, IDLE.
//  5. Half with 7 transitions (THRESH-1) as data half -> treated inactive. 8 transitions -> active.
//  6. Drop in_enable mid-bit 3 -> IDLE next clk; no out_eof/out_err. Next frame decodes normally.

Source files
------------

// File: rtl/man_demod.sv
// man_demod: Manchester subcarrier decoder (SOF check, bit decode, EOF detect); optional MAN_DEMOD_COLL_EN
module man_demod #(
    parameter int HALF_ETU = 64,
    parameter int CW       = 6,
    parameter int THRESH   = 8,
    parameter int NB_W     = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_enable,
    input  logic            in_data,
    output logic            out_data,
    output logic            out_valid,
    output logic            out_sof,
    output logic            out_eof,
    output logic            out_err,
    output logic            out_coll,
    output logic            out_busy,
    output logic [NB_W-1:0] out_nbits
);
`ifdef MAN_DEMOD_COLL_EN
    localparam logic COLL_EN = 1'b1;
`else
    localparam logic COLL_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, SOF_CHK, DATA} state_t;
    state_t          r_state, w_next;
    logic            r_s1, r_s2, r_s3, r_edge;
    logic [CW-1:0]   r_hcnt;
    logic [CW:0]     r_ecnt, w_ecnt;
    logic            r_half, r_a, r_b, r_eval, r_data;
    logic [NB_W-1:0] r_nbits;
    logic            w_wrap, w_act, w_pair;

    assign w_wrap    = r_hcnt == CW'(HALF_ETU - 1);
    assign w_ecnt    = r_ecnt + (CW + 1)'(r_edge);
    assign w_act     = w_ecnt >= (CW + 1)'(THRESH);
    assign out_nbits = r_nbits;

    // Synchronize the raw pin and register an either-polarity edge strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_s1, r_s2, r_s3, r_edge} <= '0;
        end else begin
            r_s1   <= in_data;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_edge <= r_s2 ^ r_s3;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: start on an edge, otherwise move only when a pair is evaluated
    always_comb begin
        w_next = r_state;
        if (!in_enable)            w_next = IDLE;
        else if (r_state == IDLE)  w_next = r_edge ? SOF_CHK : IDLE;
        else if (r_eval)           w_next = (out_sof || out_valid) ? DATA : IDLE;
    end

    // Pair decode into mutually exclusive strobes; out_data holds between bits
    always_comb begin
        w_pair    = r_eval && in_enable && r_state != IDLE;
        out_sof   = w_pair && r_state == SOF_CHK && r_a && !r_b;
        out_eof   = w_pair && r_state == DATA && !r_a && !r_b;
        out_coll  = w_pair && r_state == DATA && r_a && r_b && COLL_EN;
        out_valid = w_pair && r_state == DATA && ((r_a ^ r_b) || out_coll);
        out_err   = w_pair && !out_sof && !out_eof && !out_valid;
        out_data  = out_valid ? r_a : r_data;
        out_busy  = r_state != IDLE;
    end

    // Half-ETU timing frozen at the first edge; halves close on wrap and pair up A/B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt  <= '0;
            r_ecnt  <= '0;
            r_half  <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_eval  <= 1'b0;
            r_data  <= 1'b0;
            r_nbits <= '0;
        end else begin
            r_data <= out_data;
            r_eval <= 1'b0;
            if (out_valid && !(&r_nbits)) r_nbits <= r_nbits + 1'b1;
            if (w_next == IDLE) begin
                r_hcnt <= '0;
                r_ecnt <= '0;
                r_half <= 1'b0;
            end else if (r_state == IDLE) begin
                r_hcnt  <= '0;
                r_ecnt  <= (CW + 1)'(1);
                r_half  <= 1'b0;
                r_nbits <= '0;
            end else begin
                r_hcnt <= w_wrap ? '0 : r_hcnt + 1'b1;
                r_ecnt <= w_wrap ? '0 : w_ecnt;
                if (w_wrap) begin
                    r_half <= !r_half;
                    if (r_half) begin
                        r_b    <= w_act;
                        r_eval <= 1'b1;
                    end else begin
                        r_a <= w_act;
                    end
                end
            end
        end
    end
endmodule
